alu_nibble_sequencer: RTL



---
 rtl/alu_nibble_sequencer_if.sv | 35 +++
 rtl/alu_nibble_sequencer.sv | 111 +++++++++++
 2 files changed

// File: rtl/alu_nibble_sequencer_if.sv
// Request, response and ALU-slice signals of the nibble sequencer.
// slave is the sequencer's view; master is the surrounding logic plus the slice.
interface alu_nibble_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        req_cin;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_cout;
  logic        rsp_zero;

  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [1:0]  alu_opcode;
  logic        alu_cin;
  logic [3:0]  alu_result;
  logic        alu_cout;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_cin, rsp_ready, alu_result, alu_cout,
    output req_ready, rsp_valid, rsp_result, rsp_cout, rsp_zero,
           alu_a, alu_b, alu_opcode, alu_cin
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_cin, rsp_ready, alu_result, alu_cout,
    input  req_ready, rsp_valid, rsp_result, rsp_cout, rsp_zero,
           alu_a, alu_b, alu_opcode, alu_cin
  );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// Runs 16-bit add/sub/and/or through a shared 4-bit ALU slice, one nibble per
// cycle LSB first, chaining the slice carry, and returns result plus flags.
module alu_nibble_sequencer (
  input  logic                         clk,
  input  logic                         rst,
  alu_nibble_sequencer_if.slave        bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  state_e      state_q;
  logic [1:0]  k_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  op_e         op_q;
  logic        carry_q;
  logic [15:0] result_q;
  logic [15:0] result_d;
  logic        cout_q;
  logic        zero_q;

  logic        arith;
  logic [3:0]  a_nib;
  logic [3:0]  b_nib;

  always_comb begin
    arith    = (op_q == OP_ADD) || (op_q == OP_SUB);
    a_nib    = a_q[{k_q, 2'b00} +: 4];
    b_nib    = b_q[{k_q, 2'b00} +: 4];
    result_d = result_q;
    result_d[{k_q, 2'b00} +: 4] = bus.alu_result;

    // NOTE: every output gets a default first so no path leaves a latch behind.
    bus.alu_a      = 4'd0;
    bus.alu_b      = 4'd0;
    bus.alu_opcode = 2'b00;
    bus.alu_cin    = 1'b0;
    if (state_q == S_ISSUE) begin
      bus.alu_a = a_nib;
      // Subtract is a + ~b + 1 through the slice's add, so the carry chains.
      bus.alu_b      = (op_q == OP_SUB) ? ~b_nib : b_nib;
      bus.alu_opcode = (op_q == OP_SUB) ? OP_ADD : op_q;
      bus.alu_cin    = arith ? carry_q : 1'b0;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE) && !rst;
  assign bus.rsp_valid  = (state_q == S_RESP);
  assign bus.rsp_result = result_q;
  assign bus.rsp_cout   = cout_q;
  assign bus.rsp_zero   = zero_q;

  // NOTE: state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      k_q      <= 2'd0;
      a_q      <= 16'd0;
      b_q      <= 16'd0;
      op_q     <= OP_ADD;
      carry_q  <= 1'b0;
      result_q <= 16'd0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            state_q <= S_ISSUE;
            k_q     <= 2'd0;
            a_q     <= bus.req_a;
            b_q     <= bus.req_b;
            op_q    <= op_e'(bus.req_op);
            // Carry register is preloaded with the nibble-0 carry-in.
            case (op_e'(bus.req_op))
              OP_ADD:  carry_q <= bus.req_cin;
              OP_SUB:  carry_q <= 1'b1;
              default: carry_q <= 1'b0;
            endcase
          end
        end
        S_ISSUE: begin
          result_q <= result_d;
          carry_q  <= bus.alu_cout;
          k_q      <= k_q + 2'd1;
          if (k_q == 2'd3) begin
            state_q <= S_RESP;
            cout_q  <= arith & bus.alu_cout;
            zero_q  <= (result_d == 16'd0);
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
